// File: rtl/prco_fetch_pkg.sv
// Shared definitions for the PRCO instruction fetch unit: FSM state encoding and the NOP word.
package prco_fetch_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StIssue = 3'd3,
    StHold  = 3'd4
  } fetch_state_e;

  // Word presented on q_instr before anything has been issued.
  localparam logic [15:0] NopWord = 16'h0000;

endpackage

// File: rtl/prco_fetch_buf.sv
// One-entry prefetch buffer: holds a fetched word and its address until consumed or invalidated.
// Only instantiated when PRCO_FETCH_PREFETCH_EN is defined.
module prco_fetch_buf #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               inv_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] data_o,
  output logic [ADDR_W-1:0]  addr_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] data_q;
  logic [ADDR_W-1:0]  addr_q;

  // Invalidate takes priority so a jump can never leave a stale word behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else if (inv_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      addr_q  <= addr_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/prco_fetch.sv
// PRCO instruction fetch unit: owns the PC, reads instruction memory and issues each word to the
// decoder with a one-cycle q_ce pulse. Optional one-entry prefetch buffer enabled by defining
// PRCO_FETCH_PREFETCH_EN; the default build fetches strictly once per i_fetch.
module prco_fetch
  import prco_fetch_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 8,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_fetch,
  input  logic               i_jmp_en,
  input  logic [ADDR_W-1:0]  i_jmp_addr,
  output logic [ADDR_W-1:0]  q_mem_addr,
  output logic               q_mem_re,
  input  logic [INSTR_W-1:0] i_mem_data,
  input  logic               i_mem_valid,
  output logic [INSTR_W-1:0] q_instr,
  output logic               q_ce,
  output logic [ADDR_W-1:0]  q_pc,
  output logic               q_busy
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  // Set when the outstanding read belongs to a redirected stream and must be dropped.
  logic              flush_q;
  logic [ADDR_W-1:0] jmp_or_pc;
  logic [ADDR_W-1:0] jmp_or_inc;

  assign jmp_or_pc  = i_jmp_en ? i_jmp_addr : pc_q;
  assign jmp_or_inc = i_jmp_en ? i_jmp_addr : pc_q + ADDR_W'(1);

`ifdef PRCO_FETCH_PREFETCH_EN
  logic               pf_pend_q;
  logic               buf_load;
  logic               buf_inv;
  logic               buf_valid;
  logic [INSTR_W-1:0] buf_data;
  logic [ADDR_W-1:0]  buf_addr;

  // A prefetch response lands in the buffer unless it is consumed directly or flushed.
  always_comb begin
    buf_load = 1'b0;
    buf_inv  = 1'b0;
    if (state_q == StHold) begin
      buf_load = pf_pend_q && i_mem_valid && !i_jmp_en && !(i_fetch && i_en);
      buf_inv  = i_jmp_en || (i_fetch && i_en) || (!i_en && !pf_pend_q);
    end
  end

  prco_fetch_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_buf (
    .clk_i   (i_clk),
    .rst_ni  (i_reset),
    .load_i  (buf_load),
    .inv_i   (buf_inv),
    .data_i  (i_mem_data),
    .addr_i  (pc_q),
    .valid_o (buf_valid),
    .data_o  (buf_data),
    .addr_o  (buf_addr)
  );
`endif

  // Fetch FSM; every output is registered and set on the transition into the state that owns it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      q_pc       <= RESET_PC;
      q_instr    <= INSTR_W'(NopWord);
      q_ce       <= 1'b0;
      q_mem_re   <= 1'b0;
      q_mem_addr <= '0;
      q_busy     <= 1'b0;
`ifdef PRCO_FETCH_PREFETCH_EN
      pf_pend_q  <= 1'b0;
`endif
    end else begin
      q_ce     <= 1'b0;
      q_mem_re <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_en) begin
            state_q    <= StReq;
            q_mem_re   <= 1'b1;
            q_mem_addr <= pc_q;
            q_busy     <= 1'b1;
          end
        end
        StReq: begin
          state_q <= StWait;
          if (i_jmp_en) begin
            pc_q    <= i_jmp_addr;
            flush_q <= 1'b1;
          end
        end
        StWait: begin
          if (i_mem_valid) begin
            if (flush_q || i_jmp_en) begin
              // Stale response: drop it and refetch from the redirected pc.
              flush_q    <= 1'b0;
              pc_q       <= jmp_or_pc;
              state_q    <= StReq;
              q_mem_re   <= 1'b1;
              q_mem_addr <= jmp_or_pc;
            end else begin
              state_q <= StIssue;
              q_instr <= i_mem_data;
              q_pc    <= pc_q;
              q_ce    <= 1'b1;
              q_busy  <= 1'b0;
            end
          end else if (i_jmp_en) begin
            pc_q    <= i_jmp_addr;
            flush_q <= 1'b1;
          end
        end
        StIssue: begin
          // A jump here still lets the current word out but overrides the increment.
          pc_q    <= jmp_or_inc;
          state_q <= StHold;
`ifdef PRCO_FETCH_PREFETCH_EN
          if (i_en) begin
            q_mem_re   <= 1'b1;
            q_mem_addr <= jmp_or_inc;
            q_busy     <= 1'b1;
            pf_pend_q  <= 1'b1;
          end
`endif
        end
        StHold: begin
`ifdef PRCO_FETCH_PREFETCH_EN
          if (i_jmp_en) begin
            pc_q      <= i_jmp_addr;
            pf_pend_q <= 1'b0;
            if (pf_pend_q && !i_mem_valid) begin
              // Prefetch still in flight: let it drain through WAIT and discard it there.
              flush_q <= 1'b1;
              state_q <= StWait;
            end else begin
              state_q    <= StReq;
              q_mem_re   <= 1'b1;
              q_mem_addr <= i_jmp_addr;
              q_busy     <= 1'b1;
            end
          end else if (i_fetch && i_en) begin
            if (buf_valid) begin
              state_q <= StIssue;
              q_instr <= buf_data;
              q_pc    <= buf_addr;
              q_ce    <= 1'b1;
              q_busy  <= 1'b0;
            end else if (pf_pend_q && i_mem_valid) begin
              pf_pend_q <= 1'b0;
              state_q   <= StIssue;
              q_instr   <= i_mem_data;
              q_pc      <= pc_q;
              q_ce      <= 1'b1;
              q_busy    <= 1'b0;
            end else if (pf_pend_q) begin
              pf_pend_q <= 1'b0;
              state_q   <= StWait;
            end else begin
              state_q    <= StReq;
              q_mem_re   <= 1'b1;
              q_mem_addr <= pc_q;
              q_busy     <= 1'b1;
            end
          end else if (pf_pend_q) begin
            if (i_mem_valid) begin
              pf_pend_q <= 1'b0;
              q_busy    <= 1'b0;
            end
          end else if (!i_en) begin
            state_q <= StIdle;
          end
`else
          if (i_jmp_en) begin
            pc_q       <= i_jmp_addr;
            state_q    <= StReq;
            q_mem_re   <= 1'b1;
            q_mem_addr <= i_jmp_addr;
            q_busy     <= 1'b1;
          end else if (i_fetch && i_en) begin
            state_q    <= StReq;
            q_mem_re   <= 1'b1;
            q_mem_addr <= pc_q;
            q_busy     <= 1'b1;
          end else if (!i_en) begin
            state_q <= StIdle;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_prco_fetch.sv
// Randomised scoreboard bench for prco_fetch: a memory responder with random latency, a driver
// that pushes the expected (pc, word, read count) of every issue, and a monitor that checks q_ce.
module tb_prco_fetch;

  localparam int AW = 8;
  localparam int IW = 16;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_en = 1'b0;
  logic          i_fetch = 1'b0;
  logic          i_jmp_en = 1'b0;
  logic [AW-1:0] i_jmp_addr = '0;
  logic [IW-1:0] i_mem_data = '0;
  logic          i_mem_valid = 1'b0;
  logic [AW-1:0] q_mem_addr;
  logic          q_mem_re;
  logic [IW-1:0] q_instr;
  logic          q_ce;
  logic [AW-1:0] q_pc;
  logic          q_busy;

  prco_fetch #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .RESET_PC (8'h00)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en        (i_en),
    .i_fetch     (i_fetch),
    .i_jmp_en    (i_jmp_en),
    .i_jmp_addr  (i_jmp_addr),
    .q_mem_addr  (q_mem_addr),
    .q_mem_re    (q_mem_re),
    .i_mem_data  (i_mem_data),
    .i_mem_valid (i_mem_valid),
    .q_instr     (q_instr),
    .q_ce        (q_ce),
    .q_pc        (q_pc),
    .q_busy      (q_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] instr;
    int            nreads;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] mem[256];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            force_lat = 1;
  logic [AW-1:0] model_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Expected next issue: address, the memory word there, and how many reads it should take.
  task automatic push(input logic [AW-1:0] a, input int n);
    exp_t e;
    e.addr   = a;
    e.instr  = mem[a];
    e.nreads = n;
    exp_q.push_back(e);
    model_pc = a;
  endtask

  task automatic wait_ce(output int busy_cnt);
    int k;
    busy_cnt = 0;
    k = 0;
    while (k < 80) begin
      if (q_busy) busy_cnt++;
      if (q_ce) break;
      @(negedge i_clk);
      k++;
    end
    if (k == 80) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: no q_ce after 80 cycles, required one issue");
    end
  endtask

  // Called on the negedge of the ISSUE cycle. a: 0 fetch, 1 jump in ISSUE, 2 jump+fetch in HOLD,
  // 3 jump in HOLD, 4 jump during REQ/WAIT, 5 drop i_en in HOLD then re-enable.
  task automatic act(input int a, input logic [AW-1:0] t, input int lat);
    force_lat = lat;
    case (a)
      0: begin
        push(model_pc + 8'd1, 1);
        @(negedge i_clk);
        repeat ($urandom_range(0, 2)) @(negedge i_clk);
        i_fetch = 1'b1;
        @(negedge i_clk);
        i_fetch = 1'b0;
      end
      1: begin
        push(t, 1);
        i_jmp_en = 1'b1; i_jmp_addr = t;
        @(negedge i_clk);
        i_jmp_en = 1'b0; i_fetch = 1'b1;
        @(negedge i_clk);
        i_fetch = 1'b0;
      end
      2: begin
        push(t, 1);
        @(negedge i_clk);
        i_jmp_en = 1'b1; i_jmp_addr = t; i_fetch = 1'b1;
        @(negedge i_clk);
        i_jmp_en = 1'b0; i_fetch = 1'b0;
      end
      3: begin
        push(t, 1);
        @(negedge i_clk);
        i_jmp_en = 1'b1; i_jmp_addr = t;
        @(negedge i_clk);
        i_jmp_en = 1'b0;
      end
      4: begin
        push(t, 2);
        @(negedge i_clk);
        i_fetch = 1'b1;
        @(negedge i_clk);
        i_fetch = 1'b0;
        if ($urandom_range(0, 1) == 1) @(negedge i_clk);
        i_jmp_en = 1'b1; i_jmp_addr = t;
        @(negedge i_clk);
        i_jmp_en = 1'b0;
      end
      default: begin
        push(model_pc + 8'd1, 1);
        @(negedge i_clk);
        i_en = 1'b0;
        repeat (3) @(negedge i_clk);
        i_en = 1'b1;
      end
    endcase
  endtask

  // Memory: one outstanding read, data returned force_lat cycles after the strobe.
  initial begin
    logic [AW-1:0] ra;
    int            lat;
    forever begin
      @(posedge i_clk);
      #1;
      while (q_mem_re) begin
        ra  = q_mem_addr;
        lat = force_lat;
        repeat (lat) begin
          @(posedge i_clk);
          #1;
        end
        i_mem_valid = 1'b1;
        i_mem_data  = mem[ra];
        @(posedge i_clk);
        #1;
        i_mem_valid = 1'b0;
        i_mem_data  = 16'($urandom);
      end
    end
  end

  // Monitor: every q_ce must match the oldest expected issue.
  initial begin
    int            reads;
    logic [AW-1:0] last_addr;
    exp_t          e;
    reads     = 0;
    last_addr = '0;
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        reads = 0;
      end else begin
        if (q_mem_re) begin
          reads++;
          last_addr = q_mem_addr;
        end
        if (q_ce) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_issue: q_ce with pc %0h, required no issue", q_pc);
          end else begin
            e = exp_q.pop_front();
            chk("issue_pc", 32'(q_pc), 32'(e.addr));
            chk("issue_instr", 32'(q_instr), 32'(e.instr));
            chk("reads_per_issue", 32'(reads), 32'(e.nreads));
            chk("last_read_addr", 32'(last_addr), 32'(e.addr));
          end
          reads = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int bc;
    int ce_seen;
    int re_seen;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h4A12;
    mem[1] = 16'h0803;

    // Reset state, with i_en already high.
    i_en = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("rst_instr", 32'(q_instr), 32'h0);
    chk("rst_ce", 32'(q_ce), 32'h0);
    chk("rst_mem_re", 32'(q_mem_re), 32'h0);
    chk("rst_mem_addr", 32'(q_mem_addr), 32'h0);
    chk("rst_busy", 32'(q_busy), 32'h0);
    chk("rst_pc", 32'(q_pc), 32'h0);

    // First fetch needs no i_fetch.
    force_lat = 1;
    push(8'h00, 1);
    i_reset = 1'b1;
    wait_ce(bc);

    // Fetch at 0x01 with 3-cycle memory: busy for REQ plus three WAIT cycles.
    act(0, 8'h00, 3);
    wait_ce(bc);
    chk("busy_cycles", 32'(bc), 32'd4);

    act(4, 8'h40, 3);       // jump while the read is in flight
    wait_ce(bc);
    act(2, 8'hFF, 2);
    wait_ce(bc);
    act(0, 8'h00, 2);       // pc wraps 0xFF -> 0x00
    wait_ce(bc);
    act(2, 8'h10, 1);       // jump and fetch together: one read at the target
    wait_ce(bc);

    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] t;
      t = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      act($urandom_range(0, 5), t, $urandom_range(1, 4));
      wait_ce(bc);
    end

    // Reset in the middle of a read; the late response must be ignored.
    force_lat = 4;
    @(negedge i_clk);
    i_fetch = 1'b1;
    @(negedge i_clk);
    i_fetch = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
    i_en    = 1'b0;
    #1;
    chk("midrst_instr", 32'(q_instr), 32'h0);
    chk("midrst_ce", 32'(q_ce), 32'h0);
    chk("midrst_mem_re", 32'(q_mem_re), 32'h0);
    chk("midrst_mem_addr", 32'(q_mem_addr), 32'h0);
    chk("midrst_busy", 32'(q_busy), 32'h0);
    chk("midrst_pc", 32'(q_pc), 32'h0);
    exp_q.delete();
    @(negedge i_clk);
    i_reset = 1'b1;
    ce_seen = 0;
    re_seen = 0;
    repeat (8) begin
      @(negedge i_clk);
      ce_seen += int'(q_ce);
      re_seen += int'(q_mem_re);
    end
    chk("stray_valid_ce", 32'(ce_seen), 32'h0);
    chk("idle_mem_re", 32'(re_seen), 32'h0);
    chk("idle_busy", 32'(q_busy), 32'h0);

    force_lat = 2;
    push(8'h00, 1);
    i_en = 1'b1;
    wait_ce(bc);
    @(negedge i_clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
